updown_mod_counter: RTL and testbench

Parametrised successor to the team's fixed 4-bit up-counter. It counts up or down with configurable width and modulus, and supports synchronous clear, parallel load and count enable. At the count boundary it either wraps or saturates, selected by parameter. It reports a registered terminal-count pulse and a sticky boundary flag, and serves as the general-purpose timer/sequencer counter for the datapath and control blocks.

---
 rtl/updown_mod_counter.sv | 100 ++++++++++
 tb/tb_updown_mod_counter.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/updown_mod_counter.sv
// Up/down modulo counter with wrap or saturate at the boundary, a one-cycle
// terminal-count pulse and a sticky boundary flag. All outputs are registered.
module updown_mod_counter #(
    parameter int          WIDTH    = 4,
    parameter logic [31:0] MOD_MAX  = 32'd15,
    parameter bit          SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             up_dn,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             bnd_flag
);

    localparam logic [WIDTH-1:0] MAX_C  = MOD_MAX[WIDTH-1:0];
    localparam logic [WIDTH-1:0] ZERO_C = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_C  = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic             bnd_q, bnd_d;
    logic [WIDTH-1:0] load_clamp_s;
    logic             at_max_s;
    logic             at_zero_s;

    // Boundary detection and load clamping, shared by the next-state logic
    always_comb begin
        at_max_s     = (count_q == MAX_C);
        at_zero_s    = (count_q == ZERO_C);
        if (load_val > MAX_C) begin
            load_clamp_s = MAX_C;
        end else begin
            load_clamp_s = load_val;
        end
    end

    // Next-state: clr beats load beats en; boundary events raise tc and bnd
    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        bnd_d   = bnd_q;
        if (clr) begin
            count_d = ZERO_C;
            bnd_d   = 1'b0;
        end else if (load) begin
            count_d = load_clamp_s;
        end else if (en) begin
            if (up_dn) begin
                if (at_max_s) begin
                    tc_d  = 1'b1;
                    bnd_d = 1'b1;
                    if (SATURATE) begin
                        count_d = MAX_C;
                    end else begin
                        count_d = ZERO_C;
                    end
                end else begin
                    count_d = count_q + ONE_C;
                end
            end else begin
                if (at_zero_s) begin
                    tc_d  = 1'b1;
                    bnd_d = 1'b1;
                    if (SATURATE) begin
                        count_d = ZERO_C;
                    end else begin
                        count_d = MAX_C;
                    end
                end else begin
                    count_d = count_q - ONE_C;
                end
            end
        end else begin
            count_d = count_q;
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= ZERO_C;
            tc_q    <= 1'b0;
            bnd_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
            bnd_q   <= bnd_d;
        end
    end

    assign count    = count_q;
    assign tc       = tc_q;
    assign bnd_flag = bnd_q;

endmodule

// File: tb/tb_updown_mod_counter.sv
// Directed self-checking bench: three counter configurations share one
// stimulus bus; each phase checks the instance it targets.
module tb_updown_mod_counter;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       clr = 1'b0;
    logic       load = 1'b0;
    logic [3:0] load_val = 4'd0;
    logic       en = 1'b0;
    logic       up_dn = 1'b1;

    logic [3:0] cnt_a, cnt_b, cnt_c;
    logic       tc_a, tc_b, tc_c;
    logic       bnd_a, bnd_b, bnd_c;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    updown_mod_counter #(.WIDTH(4), .MOD_MAX(32'd15), .SATURATE(1'b0)) u_def (
        .clk(clk), .reset(reset), .clr(clr), .load(load), .load_val(load_val),
        .en(en), .up_dn(up_dn), .count(cnt_a), .tc(tc_a), .bnd_flag(bnd_a));

    updown_mod_counter #(.WIDTH(4), .MOD_MAX(32'd9), .SATURATE(1'b0)) u_m9w (
        .clk(clk), .reset(reset), .clr(clr), .load(load), .load_val(load_val),
        .en(en), .up_dn(up_dn), .count(cnt_b), .tc(tc_b), .bnd_flag(bnd_b));

    updown_mod_counter #(.WIDTH(4), .MOD_MAX(32'd9), .SATURATE(1'b1)) u_m9s (
        .clk(clk), .reset(reset), .clr(clr), .load(load), .load_val(load_val),
        .en(en), .up_dn(up_dn), .count(cnt_c), .tc(tc_c), .bnd_flag(bnd_c));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk3(input string tag, input logic [3:0] c, input logic t, input logic b,
                        input logic [3:0] ec, input logic et, input logic eb);
        chk({tag, ".count"}, {28'd0, c}, {28'd0, ec});
        chk({tag, ".tc"}, {31'd0, t}, {31'd0, et});
        chk({tag, ".bnd"}, {31'd0, b}, {31'd0, eb});
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0; clr = 1'b0; load = 1'b0; en = 1'b0; up_dn = 1'b1; load_val = 4'd0;
        #1;
        chk3("rst_a", cnt_a, tc_a, bnd_a, 4'd0, 1'b0, 1'b0);
        step();
        reset = 1'b1;
    endtask

    initial begin
        // Phase 1: default config counts up and wraps
        do_reset();
        en = 1'b1; up_dn = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            step();
            chk3($sformatf("p1_%0d", i), cnt_a, tc_a, bnd_a,
                 4'(i % 16), (i == 16), (i >= 16));
        end

        // Phase 2: MOD_MAX=9 wrapping, counting down from reset
        do_reset();
        en = 1'b1; up_dn = 1'b0;
        step(); chk3("p2_wrap", cnt_b, tc_b, bnd_b, 4'd9, 1'b1, 1'b1);
        step(); chk3("p2_8", cnt_b, tc_b, bnd_b, 4'd8, 1'b0, 1'b1);
        step(); chk3("p2_7", cnt_b, tc_b, bnd_b, 4'd7, 1'b0, 1'b1);
        load = 1'b1; load_val = 4'd13;
        step(); chk3("p2_clamp", cnt_b, tc_b, bnd_b, 4'd9, 1'b0, 1'b1);
        load = 1'b0;

        // Phase 3: MOD_MAX=9 saturating up from 7
        do_reset();
        load = 1'b1; load_val = 4'd7;
        step(); chk3("p3_ld", cnt_c, tc_c, bnd_c, 4'd7, 1'b0, 1'b0);
        load = 1'b0; en = 1'b1; up_dn = 1'b1;
        step(); chk3("p3_8", cnt_c, tc_c, bnd_c, 4'd8, 1'b0, 1'b0);
        step(); chk3("p3_9a", cnt_c, tc_c, bnd_c, 4'd9, 1'b0, 1'b0);
        step(); chk3("p3_9b", cnt_c, tc_c, bnd_c, 4'd9, 1'b1, 1'b1);
        step(); chk3("p3_9c", cnt_c, tc_c, bnd_c, 4'd9, 1'b1, 1'b1);
        step(); chk3("p3_9d", cnt_c, tc_c, bnd_c, 4'd9, 1'b1, 1'b1);
        en = 1'b0;

        // Phase 4: control priority with the sticky flag already set
        do_reset();
        load = 1'b1; load_val = 4'd15;
        step(); chk3("p4_ld15", cnt_a, tc_a, bnd_a, 4'd15, 1'b0, 1'b0);
        load = 1'b0; en = 1'b1;
        step(); chk3("p4_wrap", cnt_a, tc_a, bnd_a, 4'd0, 1'b1, 1'b1);
        load = 1'b1; load_val = 4'd5;
        step(); chk3("p4_ld5", cnt_a, tc_a, bnd_a, 4'd5, 1'b0, 1'b1);
        clr = 1'b1; load_val = 4'd3;
        step(); chk3("p4_clr", cnt_a, tc_a, bnd_a, 4'd0, 1'b0, 1'b0);
        clr = 1'b0;
        step(); chk3("p4_ld3", cnt_a, tc_a, bnd_a, 4'd3, 1'b0, 1'b0);
        load = 1'b0; en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(); chk3($sformatf("p4_hold%0d", i), cnt_a, tc_a, bnd_a, 4'd3, 1'b0, 1'b0);
        end

        // Phase 5: asynchronous reset between edges
        do_reset();
        load = 1'b1; load_val = 4'd15;
        step();
        load = 1'b0; en = 1'b1; up_dn = 1'b1;
        step(); chk3("p5_wrap", cnt_a, tc_a, bnd_a, 4'd0, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) step();
        chk3("p5_six", cnt_a, tc_a, bnd_a, 4'd6, 1'b0, 1'b1);
        #2 reset = 1'b0;
        #1 chk3("p5_async", cnt_a, tc_a, bnd_a, 4'd0, 1'b0, 1'b0);
        step(); chk3("p5_hold1", cnt_a, tc_a, bnd_a, 4'd0, 1'b0, 1'b0);
        step(); chk3("p5_hold2", cnt_a, tc_a, bnd_a, 4'd0, 1'b0, 1'b0);
        reset = 1'b1;
        step(); chk3("p5_resume", cnt_a, tc_a, bnd_a, 4'd1, 1'b0, 1'b0);

        // Phase 6: direction toggle across the boundary
        do_reset();
        load = 1'b1; load_val = 4'd15;
        step(); chk3("p6_ld", cnt_a, tc_a, bnd_a, 4'd15, 1'b0, 1'b0);
        load = 1'b0; en = 1'b1; up_dn = 1'b1;
        step(); chk3("p6_up", cnt_a, tc_a, bnd_a, 4'd0, 1'b1, 1'b1);
        up_dn = 1'b0;
        step(); chk3("p6_dn", cnt_a, tc_a, bnd_a, 4'd15, 1'b1, 1'b1);
        step(); chk3("p6_14", cnt_a, tc_a, bnd_a, 4'd14, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
